// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction fetch unit: default widths, reset PC
// and the sequential instruction step.
package ifu_prefetch_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned ILEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam int unsigned INST_STEP    = 4;

endpackage

// File: rtl/ifu_inst_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, inst} pairs between fetch and
// decode; flush empties it in one cycle.
module ifu_inst_fifo
   import ifu_prefetch_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN_DEF + ILEN_DEF,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign full      = (count == CW'(DEPTH));
   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching fetch stage: credit-limited in-order requests to instruction
// memory, {pc, inst} queue to decode, redirect with in-flight response discard.
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     ILEN     = ILEN_DEF,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_valid_o,
   input  logic            req_ready_i,
   output logic [XLEN-1:0] req_addr_o,
   input  logic            resp_valid_i,
   input  logic [ILEN-1:0] resp_data_i,
   input  logic            jb_i,
   input  logic [XLEN-1:0] dnpc_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [ILEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(INST_STEP);

   logic [XLEN-1:0]      fetch_pc;
   logic [XLEN-1:0]      resp_pc;
   logic [XLEN-1:0]      dnpc_aligned;
   logic [CW-1:0]        outstanding;
   logic [CW-1:0]        drop;
   logic [CW-1:0]        count;
   logic [CW:0]          credit_sum;
   logic                 full;
   logic                 req_fire;
   logic                 push;
   logic                 pop;
   logic [XLEN+ILEN-1:0] head_data;

   always_comb begin
      dnpc_aligned = {dnpc_i[XLEN-1:2], 2'b00};
      credit_sum   = {1'b0, count} + {1'b0, outstanding};
      req_valid_o  = !rst && !jb_i && (credit_sum < (CW+1)'(DEPTH)) && (drop == '0);
      req_fire     = req_valid_o && req_ready_i;
      // responses landing during a redirect belong to the old stream
      push         = resp_valid_i && !jb_i && (drop == '0);
      inst_valid_o = !rst && (count != '0) && !jb_i;
      pop          = inst_valid_o && inst_ready_i;
      req_addr_o   = rst ? '0 : fetch_pc;
      pc_o         = rst ? '0 : head_data[XLEN+ILEN-1:ILEN];
      inst_o       = rst ? '0 : head_data[ILEN-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (jb_i) begin
         fetch_pc    <= dnpc_aligned;
         resp_pc     <= dnpc_aligned;
         // every request still in flight after this cycle belongs to the old path
         outstanding <= outstanding - CW'(resp_valid_i);
         drop        <= outstanding - CW'(resp_valid_i);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + STEP;
         if (push)     resp_pc  <= resp_pc + STEP;
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_valid_i);
         if (resp_valid_i && (drop != '0)) drop <= drop - CW'(1);
      end
   end

   ifu_inst_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({resp_pc, resp_data_i}),
      .pop       (pop),
      .flush     (jb_i),
      .count     (count),
      .full      (full),
      .head_data (head_data)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
      !(resp_valid_i && (outstanding == '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: streaming, decode stall, redirects with
// drop, unaligned target and mid-stream reset.
module tb_ifu_prefetch;

   localparam logic [31:0] B = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [31:0] req_addr_o;
   logic        resp_valid_i;
   logic [31:0] resp_data_i;
   logic        jb_i;
   logic [31:0] dnpc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ifu_prefetch #(
      .XLEN     (32),
      .ILEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h8000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_o  (req_valid_o),
      .req_ready_i  (req_ready_i),
      .req_addr_o   (req_addr_o),
      .resp_valid_i (resp_valid_i),
      .resp_data_i  (resp_data_i),
      .jb_i         (jb_i),
      .dnpc_i       (dnpc_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .pc_o         (pc_o)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rv, input logic [31:0] addr, input logic jb,
                        input logic [31:0] dn);
      resp_valid_i = rv;
      resp_data_i  = rv ? inst_of(addr) : 32'h0;
      jb_i         = jb;
      dnpc_i       = dn;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_ready_i = 1'b0;
      inst_ready_i = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      req_ready_i = 1'b1;
      inst_ready_i = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      chk("rst_req_valid", 64'(req_valid_o), 64'd0);
      chk("rst_req_addr", 64'(req_addr_o), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
      chk("rst_pc", 64'(pc_o), 64'd0);

      // steady stream, 1-cycle memory
      do_reset();
      req_ready_i = 1'b1;
      inst_ready_i = 1'b1;
      for (int n = 0; n < 7; n++) begin
         drive(n >= 1, B + 32'(4 * (n - 1)), 1'b0, 32'h0);
         #1;
         chk("stream_req_valid", 64'(req_valid_o), 64'd1);
         chk("stream_addr", 64'(req_addr_o), 64'(B + 32'(4 * n)));
         chk("stream_inst_valid", 64'(inst_valid_o), 64'(n >= 2));
         if (n >= 2) begin
            chk("stream_pc", 64'(pc_o), 64'(B + 32'(4 * (n - 2))));
            chk("stream_inst", 64'(inst_o), 64'(inst_of(B + 32'(4 * (n - 2)))));
         end
         cyc();
      end

      // decode stall fills the queue, one pop frees exactly one credit
      do_reset();
      req_ready_i = 1'b1;
      inst_ready_i = 1'b0;
      for (int n = 0; n < 4; n++) begin
         drive(n >= 1, B + 32'(4 * (n - 1)), 1'b0, 32'h0);
         #1;
         chk("stall_fill_req", 64'(req_valid_o), 64'd1);
         chk("stall_fill_addr", 64'(req_addr_o), 64'(B + 32'(4 * n)));
         cyc();
      end
      drive(1'b1, B + 32'h0C, 1'b0, 32'h0);
      #1;
      chk("stall_credit_out", 64'(req_valid_o), 64'd0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      inst_ready_i = 1'b1;
      #1;
      chk("stall_full_req", 64'(req_valid_o), 64'd0);
      chk("stall_head_valid", 64'(inst_valid_o), 64'd1);
      chk("stall_head_pc", 64'(pc_o), 64'(B));
      cyc();
      inst_ready_i = 1'b0;
      #1;
      chk("stall_one_req", 64'(req_valid_o), 64'd1);
      chk("stall_one_addr", 64'(req_addr_o), 64'(B + 32'h10));
      cyc();
      drive(1'b1, B + 32'h10, 1'b0, 32'h0);
      #1;
      chk("stall_no_second_req", 64'(req_valid_o), 64'd0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("stall_head_pc2", 64'(pc_o), 64'(B + 32'h04));

      // mid-stream reset with a full queue
      rst = 1'b1;
      #1;
      chk("midrst_req_valid", 64'(req_valid_o), 64'd0);
      chk("midrst_inst_valid", 64'(inst_valid_o), 64'd0);
      chk("midrst_pc", 64'(pc_o), 64'd0);
      chk("midrst_inst", 64'(inst_o), 64'd0);
      chk("midrst_addr", 64'(req_addr_o), 64'd0);
      cyc();
      rst = 1'b0;
      req_ready_i = 1'b1;
      #1;
      chk("midrst_first_req", 64'(req_valid_o), 64'd1);
      chk("midrst_first_addr", 64'(req_addr_o), 64'(B));

      // redirect with 3 outstanding, no response in the redirect cycle
      do_reset();
      req_ready_i = 1'b1;
      inst_ready_i = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("rd3_issue", 64'(req_addr_o), 64'(B + 32'(4 * n)));
         cyc();
      end
      drive(1'b0, 32'h0, 1'b1, B + 32'h100);
      #1;
      chk("rd3_jb_req", 64'(req_valid_o), 64'd0);
      chk("rd3_jb_inst", 64'(inst_valid_o), 64'd0);
      cyc();
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, B + 32'(4 * n), 1'b0, 32'h0);
         #1;
         chk("rd3_drop_req", 64'(req_valid_o), 64'd0);
         chk("rd3_drop_inst", 64'(inst_valid_o), 64'd0);
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("rd3_new_req", 64'(req_valid_o), 64'd1);
      chk("rd3_new_addr", 64'(req_addr_o), 64'(B + 32'h100));
      chk("rd3_queue_empty", 64'(inst_valid_o), 64'd0);
      cyc();
      drive(1'b1, B + 32'h100, 1'b0, 32'h0);
      #1;
      chk("rd3_next_addr", 64'(req_addr_o), 64'(B + 32'h104));
      cyc();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("rd3_head_valid", 64'(inst_valid_o), 64'd1);
      chk("rd3_head_pc", 64'(pc_o), 64'(B + 32'h100));
      chk("rd3_head_inst", 64'(inst_o), 64'(inst_of(B + 32'h100)));

      // redirect coinciding with a response, 2 outstanding, unaligned target
      do_reset();
      req_ready_i = 1'b1;
      inst_ready_i = 1'b1;
      cyc();
      cyc();
      drive(1'b1, B, 1'b1, B + 32'h102);
      #1;
      chk("rdr_jb_req", 64'(req_valid_o), 64'd0);
      chk("rdr_jb_inst", 64'(inst_valid_o), 64'd0);
      cyc();
      drive(1'b1, B + 32'h04, 1'b0, 32'h0);
      #1;
      chk("rdr_no_push", 64'(inst_valid_o), 64'd0);
      chk("rdr_drop_req", 64'(req_valid_o), 64'd0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("rdr_dropped", 64'(inst_valid_o), 64'd0);
      chk("rdr_new_req", 64'(req_valid_o), 64'd1);
      chk("rdr_aligned_addr", 64'(req_addr_o), 64'(B + 32'h100));
      cyc();
      drive(1'b1, B + 32'h100, 1'b0, 32'h0);
      #1;
      cyc();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("rdr_head_pc", 64'(pc_o), 64'(B + 32'h100));
      chk("rdr_head_inst", 64'(inst_o), 64'(inst_of(B + 32'h100)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
